// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
package tdm_demux4_pkg;

  typedef enum logic [0:0] {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [1:0] SLOT_D3 = 2'b00;
  localparam logic [1:0] SLOT_D2 = 2'b01;
  localparam logic [1:0] SLOT_D1 = 2'b10;
  localparam logic [1:0] SLOT_D0 = 2'b11;

  localparam int unsigned NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot position counter: clear beats load-to-1 beats increment; wraps 3 -> 0.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load_one,
  input  logic       incr,
  output logic [1:0] slot
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= SLOT_D3;
    end else if (clear) begin
      slot <= SLOT_D3;
    end else if (load_one) begin
      slot <= SLOT_D2;
    end else if (incr) begin
      slot <= slot + 2'd1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM receive demux: tracks slot position, stages slots 0-2 and publishes all four channels
// together on the slot-3 beat.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter bit          SOF_REQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D0,
  output logic             S1,
  output logic             S0,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  state_e state_q, state_d;
  logic [1:0] slot;
  logic ctr_clear, ctr_load, ctr_incr;

  // Slot 3 is never staged; it goes straight to the output register.
  logic [WIDTH-1:0] stage_q [NUM_SLOTS-1];
  logic [WIDTH-1:0] stage_d [NUM_SLOTS-1];
  logic [WIDTH-1:0] out_q   [NUM_SLOTS];
  logic [WIDTH-1:0] out_d   [NUM_SLOTS];
  logic fv_q, fv_d, se_q, se_d;

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctr_clear),
    .load_one (ctr_load),
    .incr     (ctr_incr),
    .slot     (slot)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    out_d     = out_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    ctr_incr  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (in_sof) begin
            stage_d[0] = in_data;
            ctr_load   = 1'b1;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (in_sof && slot != SLOT_D3) begin
            // Early SOF: drop the partial frame and restart from this beat.
            se_d       = 1'b1;
            stage_d[0] = in_data;
            ctr_load   = 1'b1;
          end else if (!in_sof && slot == SLOT_D3 && SOF_REQ) begin
            se_d      = 1'b1;
            ctr_clear = 1'b1;
            state_d   = StHunt;
          end else begin
            ctr_incr = 1'b1;
            unique case (slot)
              SLOT_D3: stage_d[0] = in_data;
              SLOT_D2: stage_d[1] = in_data;
              SLOT_D1: stage_d[2] = in_data;
              SLOT_D0: begin
                out_d[0] = stage_q[0];
                out_d[1] = stage_q[1];
                out_d[2] = stage_q[2];
                out_d[3] = in_data;
                fv_d     = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
      stage_q <= '{default: '0};
      out_q   <= '{default: '0};
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign D3          = out_q[0];
  assign D2          = out_q[1];
  assign D1          = out_q[2];
  assign D0          = out_q[3];
  assign {S1, S0}    = slot;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: vector table with a frame scoreboard, plus
// hand-written sequences for async reset mid-frame and the SOF_REQ=0 variant.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;

  logic [7:0] d3, d2, d1, d0;
  logic       s1, s0, frame_valid, sync_err, locked;
  logic [7:0] e3, e2, e1, e0;
  logic       t1, t0, e_fv, e_se, e_lk;

  tdm_demux4 #(.WIDTH(8), .SOF_REQ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .D3(d3), .D2(d2), .D1(d1), .D0(d0), .S1(s1), .S0(s0),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
  );

  tdm_demux4 #(.WIDTH(8), .SOF_REQ(1'b0)) dut_free (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .D3(e3), .D2(e2), .D1(e1), .D0(e0), .S1(t1), .S0(t0),
    .frame_valid(e_fv), .sync_err(e_se), .locked(e_lk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        sof;
    logic [7:0]  data;
    logic        fv;
    logic        se;
    logic        lk;
    logic [1:0]  slot;
    logic [31:0] frame;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] cur_frame;
  vec_t tbl [$];

  function automatic vec_t mk(input logic v, input logic sof, input logic [7:0] data,
                              input logic fv, input logic se, input logic lk,
                              input logic [1:0] slot, input logic [31:0] frame);
    vec_t r;
    r.v = v; r.sof = sof; r.data = data; r.fv = fv; r.se = se; r.lk = lk;
    r.slot = slot; r.frame = frame;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t r);
    in_valid = r.v;
    in_sof   = r.sof;
    in_data  = r.data;
    if (r.fv) sb.push_back(r.frame);
    @(posedge clk);
    #1;
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, r.fv});
    if (frame_valid) begin
      if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else cur_frame = sb.pop_front();
    end
    chk("channels", {d3, d2, d1, d0}, cur_frame);
    chk("sync_err", {31'd0, sync_err}, {31'd0, r.se});
    chk("locked", {31'd0, locked}, {31'd0, r.lk});
    chk("slot", {30'd0, s1, s0}, {30'd0, r.slot});
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cur_frame = '0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; cur_frame = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_channels", {d3, d2, d1, d0}, 32'd0);
    chk("rst_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_slot", {30'd0, s1, s0}, 32'd0);

    // Basic frame, then missing SOF at slot 0 drops to hunt.
    tbl.push_back(mk(1, 1, 8'hA0, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'hA1, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 0, 8'hA2, 0, 0, 1, 2'd3, 0));
    tbl.push_back(mk(1, 0, 8'hA3, 1, 0, 1, 2'd0, 32'hA0A1A2A3));
    tbl.push_back(mk(1, 0, 8'h55, 0, 1, 0, 2'd0, 0));
    // Hunt ignores beats without SOF and idle cycles.
    tbl.push_back(mk(1, 0, 8'h11, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(1, 0, 8'h22, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(1, 1, 8'h01, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 0, 8'h03, 0, 0, 1, 2'd3, 0));
    tbl.push_back(mk(1, 0, 8'h04, 1, 0, 1, 2'd0, 32'h01020304));
    // Early SOF restarts the frame.
    tbl.push_back(mk(1, 1, 8'h10, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'h20, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 1, 8'h30, 0, 1, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'h40, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 0, 8'h50, 0, 0, 1, 2'd3, 0));
    tbl.push_back(mk(1, 0, 8'h60, 1, 0, 1, 2'd0, 32'h30405060));
    // Gaps in in_valid hold everything.
    tbl.push_back(mk(1, 1, 8'hAA, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(0, 1, 8'hEE, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'hBB, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 0, 8'hCC, 0, 0, 1, 2'd3, 0));
    tbl.push_back(mk(1, 0, 8'hDD, 1, 0, 1, 2'd0, 32'hAABBCCDD));
    // Back-to-back frame at full rate.
    tbl.push_back(mk(1, 1, 8'hC1, 0, 0, 1, 2'd1, 0));
    tbl.push_back(mk(1, 0, 8'hC2, 0, 0, 1, 2'd2, 0));
    tbl.push_back(mk(1, 0, 8'hC3, 0, 0, 1, 2'd3, 0));
    tbl.push_back(mk(1, 0, 8'hC4, 1, 0, 1, 2'd0, 32'hC1C2C3C4));

    foreach (tbl[i]) apply(tbl[i]);

    // Async reset after the slot-2 beat.
    apply(mk(1, 1, 8'hE0, 0, 0, 1, 2'd1, 0));
    apply(mk(1, 0, 8'hE1, 0, 0, 1, 2'd2, 0));
    apply(mk(1, 0, 8'hE2, 0, 0, 1, 2'd3, 0));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_channels", {d3, d2, d1, d0}, 32'd0);
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
    chk("async_rst_slot", {30'd0, s1, s0}, 32'd0);
    cur_frame = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(1, 1, 8'hF0, 0, 0, 1, 2'd1, 0));
    apply(mk(1, 0, 8'hF1, 0, 0, 1, 2'd2, 0));
    apply(mk(1, 0, 8'hF2, 0, 0, 1, 2'd3, 0));
    apply(mk(1, 0, 8'hF3, 1, 0, 1, 2'd0, 32'hF0F1F2F3));

    // Same stimulus to both variants: SOF required vs free-running after first frame.
    do_reset();
    apply(mk(1, 1, 8'h01, 0, 0, 1, 2'd1, 0));
    apply(mk(1, 0, 8'h02, 0, 0, 1, 2'd2, 0));
    apply(mk(1, 0, 8'h03, 0, 0, 1, 2'd3, 0));
    apply(mk(1, 0, 8'h04, 1, 0, 1, 2'd0, 32'h01020304));
    chk("free_fv1", {31'd0, e_fv}, 32'd1);
    chk("free_frame1", {e3, e2, e1, e0}, 32'h01020304);
    apply(mk(1, 0, 8'h05, 0, 1, 0, 2'd0, 0));
    chk("free_sync_err", {31'd0, e_se}, 32'd0);
    chk("free_locked", {31'd0, e_lk}, 32'd1);
    chk("free_slot", {30'd0, t1, t0}, 32'd1);
    apply(mk(1, 0, 8'h06, 0, 0, 0, 2'd0, 0));
    apply(mk(1, 0, 8'h07, 0, 0, 0, 2'd0, 0));
    apply(mk(1, 0, 8'h08, 0, 0, 0, 2'd0, 0));
    chk("free_fv2", {31'd0, e_fv}, 32'd1);
    chk("free_frame2", {e3, e2, e1, e0}, 32'h05060708);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("fv_one_cycle", {31'd0, frame_valid}, 32'd0);
    chk("free_fv_one_cycle", {31'd0, e_fv}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
